// File: rtl/pbit_pkg.sv
// Shared constants, FSM state type and LFSR step function for the p-bit Gibbs array.
package pbit_pkg;

  localparam int INT_SIZE   = 8;
  localparam int FLOAT_SIZE = 24;
  localparam int ELE        = INT_SIZE + FLOAT_SIZE;

  localparam logic [31:0] SEED_DEFAULT = 32'hACE1_2468;
  // Galois feedback mask for taps 32, 22, 2, 1
  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DECIDE,
    S_FIN
  } state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/pbit_gibbs_array_if.sv
// Control, configuration and status bundle of the p-bit Gibbs array.
interface pbit_gibbs_array_if #(
  parameter int N = 4,
  parameter int W = pbit_pkg::ELE
);
  localparam int IDX_W = $clog2(N);

  logic             start;
  logic [15:0]      num_sweeps;
  logic [2:0]       beta_shift;
  logic             w_we;
  logic [IDX_W-1:0] w_row;
  logic [IDX_W-1:0] w_col;
  logic [W-1:0]     w_data;
  logic             b_we;
  logic [IDX_W-1:0] b_addr;
  logic [W-1:0]     b_data;
  logic             seed_we;
  logic [31:0]      seed;
  logic             busy;
  logic             done;
  logic [15:0]      sweep_cnt;
  logic [N-1:0]     spins;

  modport master (
    output start, num_sweeps, beta_shift,
    output w_we, w_row, w_col, w_data,
    output b_we, b_addr, b_data,
    output seed_we, seed,
    input  busy, done, sweep_cnt, spins
  );

  modport slave (
    input  start, num_sweeps, beta_shift,
    input  w_we, w_row, w_col, w_data,
    input  b_we, b_addr, b_data,
    input  seed_we, seed,
    output busy, done, sweep_cnt, spins
  );

endinterface

// File: rtl/pbit_lfsr32.sv
// 32-bit Galois LFSR; zero seed falls back to the default so the register never locks up.
module pbit_lfsr32 #(
  parameter logic [31:0] SEED_DEFAULT = pbit_pkg::SEED_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] value
);
  import pbit_pkg::*;

  always_ff @(posedge CLK) begin
    if (RST) begin
      value <= SEED_DEFAULT;
    end else if (load) begin
      value <= (seed == 32'd0) ? SEED_DEFAULT : seed;
    end else if (advance) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/pbit_gibbs_array.sv
// N-node p-bit network with weight/bias register files, updated by sequential Gibbs sweeps.
//   state    | meaning
//   S_IDLE   | waiting for start; register files and seed writable
//   S_ACC    | accumulating J[i][j] terms for node i, one column per cycle
//   S_DECIDE | compare scaled field against LFSR sample, update spins[i]
//   S_FIN    | one-cycle done pulse, return to idle
module pbit_gibbs_array #(
  parameter int          N            = 4,
  parameter int          INT_SIZE     = pbit_pkg::INT_SIZE,
  parameter int          FLOAT_SIZE   = pbit_pkg::FLOAT_SIZE,
  parameter logic [31:0] SEED_DEFAULT = pbit_pkg::SEED_DEFAULT
) (
  input logic               CLK,
  input logic               RST,
  pbit_gibbs_array_if.slave bus
);
  import pbit_pkg::*;

  localparam int W     = INT_SIZE + FLOAT_SIZE;
  localparam int IDX_W = $clog2(N);
  localparam int ACC_W = W + IDX_W + 8;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t                  state;
  logic signed [W-1:0]     jmat [N][N];
  logic signed [W-1:0]     bias [N];
  logic signed [ACC_W-1:0] acc;
  logic [IDX_W-1:0]        node;
  logic [IDX_W-1:0]        col;
  logic [15:0]             sweeps_lat;
  logic [2:0]              beta_lat;
  logic [N-1:0]            spins;
  logic                    busy;
  logic                    done;
  logic [15:0]             sweep_cnt;

  logic                    idle;
  logic                    lfsr_load;
  logic                    lfsr_adv;
  logic [31:0]             lfsr_value;

  logic signed [W-1:0]     w_sel;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] term;
  logic [IDX_W-1:0]        bias_idx;
  logic signed [W-1:0]     bias_sel;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] z;
  logic signed [ACC_W-1:0] r_ext;

  assign idle      = (state == S_IDLE);
  assign lfsr_load = idle & bus.seed_we;
  assign lfsr_adv  = (state == S_DECIDE);

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.sweep_cnt = sweep_cnt;
  assign bus.spins     = spins;

  pbit_lfsr32 #(.SEED_DEFAULT(SEED_DEFAULT)) u_lfsr (
    .CLK     (CLK),
    .RST     (RST),
    .load    (lfsr_load),
    .seed    (bus.seed),
    .advance (lfsr_adv),
    .value   (lfsr_value)
  );

  // Sign-select replaces a multiply: spin +1 adds J, spin -1 subtracts it.
  always_comb begin
    w_sel = jmat[node][col];
    w_ext = {{(ACC_W - W){w_sel[W-1]}}, w_sel};
    term  = '0;
    if (col != node) begin
      term = spins[col] ? w_ext : -w_ext;
    end
    bias_idx = '0;
    if (state == S_DECIDE && node != LAST) begin
      bias_idx = node + 1'b1;
    end
    bias_sel = bias[bias_idx];
    bias_ext = {{(ACC_W - W){bias_sel[W-1]}}, bias_sel};
    z        = acc <<< beta_lat;
    r_ext    = {{(ACC_W - FLOAT_SIZE - 1){lfsr_value[FLOAT_SIZE]}}, lfsr_value[FLOAT_SIZE:0]};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < N; r++) begin
        bias[r] <= '0;
        for (int c = 0; c < N; c++) begin
          jmat[r][c] <= '0;
        end
      end
    end else if (idle) begin
      if (bus.w_we) jmat[bus.w_row][bus.w_col] <= bus.w_data;
      if (bus.b_we) bias[bus.b_addr] <= bus.b_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      acc        <= '0;
      node       <= '0;
      col        <= '0;
      sweeps_lat <= '0;
      beta_lat   <= '0;
      spins      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sweep_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            sweeps_lat <= bus.num_sweeps;
            beta_lat   <= bus.beta_shift;
            sweep_cnt  <= '0;
            node       <= '0;
            col        <= '0;
            acc        <= bias_ext;
            if (bus.num_sweeps == 16'd0) begin
              state <= S_FIN;
            end else begin
              state <= S_ACC;
              busy  <= 1'b1;
            end
          end
        end
        S_ACC: begin
          acc <= acc + term;
          if (col == LAST) begin
            col   <= '0;
            state <= S_DECIDE;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_DECIDE: begin
          spins[node] <= (z >= r_ext);
          acc         <= bias_ext;
          if (node != LAST) begin
            node  <= node + 1'b1;
            state <= S_ACC;
          end else begin
            node      <= '0;
            sweep_cnt <= sweep_cnt + 16'd1;
            state     <= (sweep_cnt + 16'd1 == sweeps_lat) ? S_FIN : S_ACC;
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
